zero_run_detector: RTL
======================

# zero_run_detector

Parametrised, clocked successor to the combinational 8-bit zero detector. It samples a WIDTH-bit word on each valid cycle and registers a zero flag and a leading-zero count. It also tracks the run length of consecutive all-zero words and raises a sticky alarm once that run reaches THRESH. It sits on datapath monitor taps, for example stuck-bus and idle-link detection, and feeds status registers.

## Interface
- WIDTH, 8: sample width in bits, ≥ 2; bit WIDTH-1 is the MSB.
- THRESH, 4: consecutive zero words that trigger the alarm, 1 ≤ THRESH ≤ 2^CNT_W − 1.
- CNT_W, 8: run-length counter width.
- LZ_W, derived as clog2(WIDTH+1): leading-zero-count width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert and active-low.
- in_valid  in  1  in_data is sampled this cycle.
- in_data  in  WIDTH  sample word.
- clear  in  1  synchronous clear of run_len, alarm and the FSM.
- out_valid  out  1  registered copy of in_valid.
- is_zero  out  1  last sampled word was all zeros.
- lzc  out  LZ_W  leading zeros of the last sampled word counted from the MSB; WIDTH when the word is zero.
- run_len  out  CNT_W  current consecutive-zero count, saturating at 2^CNT_W − 1.
- alarm  out  1  sticky; set when run_len reaches THRESH.

## Operation
- FSM states:
  - IDLE (00): no zero run in progress.
  - RUN (01): zero run in progress, below threshold.
  - ALARM (10): threshold reached.
- Transitions on in_valid:
  - IDLE, zero word: run_len = 1. Go to ALARM if THRESH == 1, else RUN.
  - IDLE, nonzero word: stay in IDLE.
  - RUN, zero word: run_len + 1. Go to ALARM when the new value equals THRESH.
  - RUN, nonzero word: run_len = 0, go to IDLE.
  - ALARM, zero word: run_len increments, saturating.
  - ALARM, nonzero word: run_len = 0, stay in ALARM.
- alarm = (state == ALARM), and is registered.
- Cycles without in_valid hold all state and all outputs. is_zero and lzc keep the last sample.
- clear: the FSM goes to IDLE, run_len = 0 and alarm = 0. If in_valid is high in the same cycle, the sample is evaluated against the cleared state. Example: clear with a zero word gives run_len = 1 and state RUN, or ALARM if THRESH == 1.
- Saturation: run_len never wraps. At the maximum it holds, and the state stays ALARM.
- lzc: the number of 0 bits above the highest 1 bit. Examples for WIDTH = 8: 8'b0001_0000 gives 3; 8'b1000_0000 gives 0; 0 gives 8.
- Do not use reduction or priority operators across the full WIDTH in one expression. Build both the zero flag and lzc as a balanced pairwise OR / merge tree.

## Timing
- Latency is 1 cycle. A sample accepted at edge n shows on out_valid, is_zero, lzc, run_len and alarm after edge n.
- Reset values while rst_n is low: out_valid 0, is_zero 0, lzc 0, run_len 0, alarm 0, state IDLE.
- Assertion is immediate (asynchronous). Deassertion takes effect at the next edge.
- Reset in the middle of a run discards the run. The first sample after release counts from 0.
- No back-pressure; a new sample can be accepted every cycle.
- Alarm timing with THRESH = 4: after 4 back-to-back zero samples, alarm rises on the edge that captures the 4th sample.

## Structure
- Shared header zero_defs.vh holds:
  - state encodings ST_IDLE, ST_RUN, ST_ALARM;
  - the clog2 function used for LZ_W.
- One combinational sub-module, zero_lzc_tree #(WIDTH): in_data → is_zero, lzc.
  - Implemented as a recursive or generate-built pairwise tree.
  - Non-power-of-two WIDTH is zero-padded at the LSB end, and the count is clamped to WIDTH.
- Top level: the FSM, the saturating counter and the output registers.

## Test plan
- Reset: hold rst_n = 0 with activity on in_data. All outputs must be 0. Release, send 8'h00. Expect is_zero = 1, lzc = 8, run_len = 1, alarm = 0 one cycle later.
- Threshold (THRESH = 4): send 00, 00, 00, 00. run_len steps 1, 2, 3, 4 and alarm rises with 4. Then send 8'h01: run_len = 0 and alarm stays 1.
- Run broken before threshold: send 00, 00, 8'h80, 00. run_len goes 1, 2, 0, 1; lzc goes 8, 8, 0, 8; alarm stays 0.
- Clear with a concurrent sample: while in ALARM, assert clear together with in_valid and 8'h00. Expect alarm = 0 and run_len = 1. Repeat with 8'h10: expect run_len = 0 and lzc = 3.
- Saturation (CNT_W = 3, THRESH = 2): 10 consecutive zero samples. run_len stops at 7 and never wraps; alarm stays 1.
- Gaps and mid-run reset: insert idle cycles between zero samples and check all outputs hold. Pulse rst_n low mid-run and check outputs clear immediately; the next zero sample gives run_len = 1. Run the same with WIDTH = 5 and data 5'b00100 → lzc = 2.

Source files
------------

// File: rtl/zero_run_detector_pkg.sv
// Shared definitions for the zero run detector: FSM state encodings and the
// ceiling-log2 helper used to size the leading-zero count.
package zero_run_detector_pkg;

    // Run tracker states. The encodings are fixed so status readers can
    // decode a captured state value directly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_ALARM = 2'b10
    } run_state_t;

    // Ceiling log2 usable in constant expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/zero_run_detector_lzc.sv
// Combinational zero flag and leading-zero counter built as a balanced
// pairwise tree. Each node reports whether its slice is all zeros and how
// many zeros lead it; a parent takes the upper half's count unless that half
// is empty, in which case it adds the half size to the lower half's count.
// Widths that are not a power of two are padded with zeros at the LSB end
// and the all-zero count is clamped back to WIDTH.
module zero_lzc_tree
    import zero_run_detector_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int LZ_W = clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_data,
    output logic             is_zero,
    output logic [LZ_W-1:0]  lzc
);

    localparam int PAD_W = 1 << clog2(WIDTH);

    generate
        if (WIDTH == 1) begin : g_leaf
            // A single bit leads with one zero exactly when it is zero.
            assign is_zero = ~in_data[0];
            assign lzc     = ~in_data;
        end else if (PAD_W != WIDTH) begin : g_pad
            localparam int PAD_LZ_W = clog2(PAD_W + 1);

            logic [PAD_W-1:0]    padded;
            logic                pad_zero;
            logic [PAD_LZ_W-1:0] pad_lzc;

            // LSB-side padding leaves the count of any nonzero word unchanged.
            assign padded = {in_data, {(PAD_W - WIDTH){1'b0}}};

            zero_lzc_tree #(
                .WIDTH (PAD_W)
            ) u_pad (
                .in_data (padded),
                .is_zero (pad_zero),
                .lzc     (pad_lzc)
            );

            // Only an all-zero word can count past WIDTH; clamp it back.
            assign is_zero = pad_zero;
            assign lzc     = (pad_lzc > PAD_LZ_W'(WIDTH)) ? LZ_W'(WIDTH)
                                                          : LZ_W'(pad_lzc);
        end else begin : g_split
            localparam int HALF      = WIDTH / 2;
            localparam int HALF_LZ_W = clog2(HALF + 1);

            logic                 hi_zero;
            logic                 lo_zero;
            logic [HALF_LZ_W-1:0] hi_lzc;
            logic [HALF_LZ_W-1:0] lo_lzc;

            zero_lzc_tree #(
                .WIDTH (HALF)
            ) u_hi (
                .in_data (in_data[WIDTH-1:HALF]),
                .is_zero (hi_zero),
                .lzc     (hi_lzc)
            );

            zero_lzc_tree #(
                .WIDTH (HALF)
            ) u_lo (
                .in_data (in_data[HALF-1:0]),
                .is_zero (lo_zero),
                .lzc     (lo_lzc)
            );

            // Merge: an empty upper half passes the count through to the
            // lower half, offset by the upper half's width.
            assign is_zero = hi_zero & lo_zero;
            assign lzc     = hi_zero ? (LZ_W'(HALF) + LZ_W'(lo_lzc))
                                     : LZ_W'(hi_lzc);
        end
    endgenerate

endmodule

// File: rtl/zero_run_detector.sv
// Clocked zero detector with run-length tracking. Every valid sample updates
// the registered zero flag and leading-zero count, advances a saturating
// count of consecutive all-zero words, and drives a sticky alarm once that
// count reaches THRESH. A synchronous clear resets the run tracking; a sample
// arriving with the clear is judged against the cleared state.
module zero_run_detector
    import zero_run_detector_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int THRESH = 4,
    parameter int CNT_W  = 8,
    localparam int LZ_W  = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             out_valid,
    output logic             is_zero,
    output logic [LZ_W-1:0]  lzc,
    output logic [CNT_W-1:0] run_len,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] RUN_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_MAX    = '1;
    localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(THRESH);

    run_state_t       state;
    run_state_t       base_state;
    run_state_t       next_state;
    logic [CNT_W-1:0] base_run;
    logic [CNT_W-1:0] next_run;
    logic             word_zero;
    logic [LZ_W-1:0]  word_lzc;

    zero_lzc_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .in_data (in_data),
        .is_zero (word_zero),
        .lzc     (word_lzc)
    );

    // Next run state for the current sample, starting from the cleared state
    // when clear accompanies it.
    always_comb begin
        base_state = clear ? ST_IDLE : state;
        base_run   = clear ? '0 : run_len;
        next_state = base_state;
        next_run   = base_run;
        case (base_state)
            ST_IDLE: begin
                if (word_zero) begin
                    next_run   = RUN_ONE;
                    next_state = (THRESH == 1) ? ST_ALARM : ST_RUN;
                end else begin
                    next_run   = '0;
                end
            end
            ST_RUN: begin
                if (word_zero) begin
                    next_run = base_run + RUN_ONE;
                    if (next_run == THRESH_CNT) begin
                        next_state = ST_ALARM;
                    end
                end else begin
                    next_run   = '0;
                    next_state = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (word_zero) begin
                    if (base_run != RUN_MAX) begin
                        next_run = base_run + RUN_ONE;
                    end
                end else begin
                    next_run = '0;
                end
            end
            default: begin
                next_run   = '0;
                next_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers: samples update everything, a lone clear
    // resets only the run tracking, and idle cycles hold all values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            run_len   <= '0;
            alarm     <= 1'b0;
            out_valid <= 1'b0;
            is_zero   <= 1'b0;
            lzc       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state   <= next_state;
                run_len <= next_run;
                alarm   <= (next_state == ST_ALARM);
                is_zero <= word_zero;
                lzc     <= word_lzc;
            end else if (clear) begin
                state   <= ST_IDLE;
                run_len <= '0;
                alarm   <= 1'b0;
            end
        end
    end

endmodule
